// File: rtl/rs_error_polynomial_pkg.sv
// rs_pkg: shared GF(2^8) definitions for the CCSDS RS(255,223) decoder.
//   GF_POLY : field polynomial x^8+x^7+x^2+x+1, alpha = 8'h02
//   NSYM    : syndromes per codeword (2t)
//   T       : correction capability (lambda has T+1 coefficients)
//   gf_mul  : combinational shift-and-add multiply reduced by GF_POLY
//   gf_inv  : multiplicative inverse as a^254 (result for 0 is meaningless)
//   bm_state_e : Berlekamp-Massey FSM states, exported for observation
package rs_pkg;

  localparam logic [8:0] GF_POLY = 9'h187;
  localparam int         NSYM    = 32;
  localparam int         T       = 16;

  typedef logic [7:0] gf_t;

  typedef enum logic [1:0] {
    BM_IDLE   = 2'd0,
    BM_DISC   = 2'd1,
    BM_UPDATE = 2'd2,
    BM_DONE   = 2'd3
  } bm_state_e;

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t p;
    p = '0;
    // MSB-first Horner form: multiply accumulator by x, reduce, add a.
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? GF_POLY[7:0] : 8'h00);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic gf_t gf_inv(input gf_t a);
    gf_t p;
    gf_t r;
    // a^254 = a^2 * a^4 * ... * a^128
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_bm_discrepancy.sv
// rs_bm_discrepancy: 17-term GF(2^8) dot product of the current locator
// against the syndrome window ending at S[r].
//   lambda_int : current locator coefficients, index = power of x
//   synd       : latched syndromes S0..S31
//   r          : iteration index (0..31)
//   delta      : XOR over i = 0..min(r,T) of lambda_int[i] * S[r-i]
module rs_bm_discrepancy
  import rs_pkg::*;
(
  input  gf_t        lambda_int [T:0],
  input  gf_t        synd       [NSYM-1:0],
  input  logic [5:0] r,
  output gf_t        delta
);

  logic [5:0] idx;

  always_comb begin
    delta = '0;
    idx   = '0;
    for (int i = 0; i <= T; i++) begin
      // Terms reaching below S0 do not exist yet in early iterations.
      if (r >= 6'(i)) begin
        idx   = r - 6'(i);
        delta = delta ^ gf_mul(lambda_int[i], synd[idx[4:0]]);
      end
    end
  end

endmodule

// File: rtl/rs_error_polynomial.sv
// rs_error_polynomial: Berlekamp-Massey error-locator solver, RS(255,223).
//   clk_in, rst_in      : clock, synchronous active-low reset
//   new_cvcdu           : marks a new codeword's syndrome set
//   data_valid_in       : syndrome array valid; start = new_cvcdu & data_valid_in
//   syndrome[31:0]      : S0..S31
//   lambda[16:0]        : final locator, lambda[i] multiplies x^i
//   lambda_valid        : one-cycle pulse when results are final
//   num_errors          : final LFSR length L, saturated at T
//   fail                : L exceeded T during the run (uncorrectable)
//   bm_state            : FSM state for observation
// Handshake: start is accepted on any edge where new_cvcdu and data_valid_in
// are both high (aborting any run in flight); there is no backpressure, and
// results are held until the next DONE or reset.
module rs_error_polynomial
  import rs_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_cvcdu,
  input  gf_t        syndrome [NSYM-1:0],
  input  logic       data_valid_in,
  output gf_t        lambda   [T:0],
  output logic       lambda_valid,
  output logic [4:0] num_errors,
  output logic       fail,
  output bm_state_e  bm_state
);

  bm_state_e  state, state_nxt;
  gf_t        synd_q [NSYM-1:0];
  gf_t        lam_q  [T:0];
  gf_t        bb_q   [T:0];
  gf_t        lam_t  [T:0];
  gf_t        xb     [T:0];
  gf_t        b_q, delta_q, delta_c, coef;
  logic [5:0] len_q, r_q, len_new;
  logic       fail_q;
  logic       start;
  logic       grow;

  assign start    = new_cvcdu && data_valid_in;
  assign bm_state = state;

  rs_bm_discrepancy u_disc (
    .lambda_int (lam_q),
    .synd       (synd_q),
    .r          (r_q),
    .delta      (delta_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      BM_IDLE:   state_nxt = BM_IDLE;
      BM_DISC:   state_nxt = BM_UPDATE;
      BM_UPDATE: state_nxt = (r_q == 6'(NSYM - 1)) ? BM_DONE : BM_DISC;
      BM_DONE:   state_nxt = BM_IDLE;
      default:   state_nxt = BM_IDLE;
    endcase
    if (start) state_nxt = BM_DISC;
  end

  // Candidate locator T(x) = lambda - (delta / b) * x * B(x); the x^17 term
  // of x*B is simply not formed.
  always_comb begin
    coef  = gf_mul(delta_q, gf_inv(b_q));
    xb[0] = '0;
    for (int i = 1; i <= T; i++) xb[i] = bb_q[i-1];
    for (int i = 0; i <= T; i++) lam_t[i] = lam_q[i] ^ gf_mul(coef, xb[i]);
    grow    = (delta_q != '0) && ({len_q, 1'b0} <= {1'b0, r_q});
    len_new = grow ? (r_q + 6'd1 - len_q) : len_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= BM_IDLE;
      synd_q       <= '{default: '0};
      lam_q        <= '{default: '0};
      bb_q         <= '{default: '0};
      b_q          <= '0;
      delta_q      <= '0;
      len_q        <= '0;
      r_q          <= '0;
      fail_q       <= 1'b0;
      lambda       <= '{default: '0};
      lambda_valid <= 1'b0;
      num_errors   <= '0;
      fail         <= 1'b0;
    end else begin
      state        <= state_nxt;
      lambda_valid <= 1'b0;
      if (start) begin
        synd_q   <= syndrome;
        lam_q    <= '{default: '0};
        lam_q[0] <= 8'h01;
        bb_q     <= '{default: '0};
        bb_q[0]  <= 8'h01;
        b_q      <= 8'h01;
        delta_q  <= '0;
        len_q    <= '0;
        r_q      <= '0;
        fail_q   <= 1'b0;
      end else begin
        case (state)
          BM_DISC: delta_q <= delta_c;
          BM_UPDATE: begin
            if (delta_q == '0) begin
              bb_q <= xb;
            end else if (grow) begin
              bb_q  <= lam_q;
              b_q   <= delta_q;
              lam_q <= lam_t;
            end else begin
              lam_q <= lam_t;
              bb_q  <= xb;
            end
            len_q <= len_new;
            r_q   <= r_q + 6'd1;
            if (len_new > 6'(T)) fail_q <= 1'b1;
          end
          BM_DONE: begin
            lambda       <= lam_q;
            num_errors   <= (len_q > 6'(T)) ? 5'(T) : len_q[4:0];
            fail         <= fail_q;
            lambda_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_error_polynomial.sv
module tb_rs_error_polynomial;
  import rs_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       new_cvcdu;
  logic       data_valid_in;
  gf_t        syndrome [NSYM-1:0];
  gf_t        lambda   [T:0];
  logic       lambda_valid;
  logic [4:0] num_errors;
  logic       fail;
  bm_state_e  bm_state;

  int errors = 0;
  int checks = 0;
  logic [135:0] snap;

  rs_error_polynomial dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .new_cvcdu     (new_cvcdu),
    .syndrome      (syndrome),
    .data_valid_in (data_valid_in),
    .lambda        (lambda),
    .lambda_valid  (lambda_valid),
    .num_errors    (num_errors),
    .fail          (fail),
    .bm_state      (bm_state)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;

  typedef struct {
    int         pat;   // 0 zeros, 1 S_i=e, 2 alpha^i, 3 1^alpha^i
    gf_t        e;
    gf_t        l0, l1, l2;
    logic [4:0] ne;
    logic       fl;
    string      name;
  } vec_t;

  vec_t vecs [5];

  gf_t fs [32] = '{8'd23, 8'd75, 8'd152, 8'd55, 8'd84, 8'd92, 8'd239, 8'd58,
                   8'd75, 8'd162, 8'd90, 8'd28, 8'd236, 8'd127, 8'd202, 8'd8,
                   8'd64, 8'd67, 8'd119, 8'd31, 8'd77, 8'd17, 8'd190, 8'd182,
                   8'd96, 8'd99, 8'd18, 8'd38, 8'd31, 8'd119, 8'd216, 8'd138};

  function automatic gf_t xtime(input gf_t v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h87 : 8'h00);
  endfunction

  function automatic logic [135:0] pack_lam();
    logic [135:0] p;
    p = '0;
    for (int i = 0; i <= T; i++) p[i*8 +: 8] = lambda[i];
    return p;
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic load_pattern(input int pat, input gf_t e);
    gf_t a;
    a = 8'h01;
    for (int i = 0; i < NSYM; i++) begin
      case (pat)
        0:       syndrome[i] = 8'h00;
        1:       syndrome[i] = e;
        2:       syndrome[i] = a;
        3:       syndrome[i] = a ^ 8'h01;
        default: syndrome[i] = fs[i];
      endcase
      a = xtime(a);
    end
  endtask

  task automatic start_run(input int pat, input gf_t e);
    @(posedge clk_in); #1;
    snap = pack_lam();
    load_pattern(pat, e);
    new_cvcdu = 1'b1;
    data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    new_cvcdu = 1'b0;
    data_valid_in = 1'b0;
  endtask

  // Counts edges after the start edge until lambda_valid, plus total pulses
  // in a 100-edge window; also flags any output change before the pulse.
  task automatic run_wait(output int lat, output int pulses, output logic held);
    lat = -1;
    pulses = 0;
    held = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_in); #1;
      if (lambda_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end else if (lat < 0 && pack_lam() !== snap) begin
        held = 1'b0;
      end
    end
  endtask

  initial begin
    int lat, pulses, deg;
    logic held;
    logic [135:0] exp_l, cap;
    logic [4:0] cap_ne;
    logic cap_fl;
    int unstable;

    vecs[0] = '{0, 8'h00, 8'h01, 8'h00, 8'h00, 5'd0, 1'b0, "zeros"};
    vecs[1] = '{1, 8'h01, 8'h01, 8'h01, 8'h00, 5'd1, 1'b0, "ones"};
    vecs[2] = '{2, 8'h00, 8'h01, 8'h02, 8'h00, 5'd1, 1'b0, "alpha"};
    vecs[3] = '{3, 8'h00, 8'h01, 8'h03, 8'h02, 5'd2, 1'b0, "two_err"};
    vecs[4] = '{1, 8'h05, 8'h01, 8'h01, 8'h00, 5'd1, 1'b0, "e5_at_1"};

    rst_in = 1'b0;
    new_cvcdu = 1'b0;
    data_valid_in = 1'b0;
    load_pattern(0, 8'h00);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_lambda", pack_lam(), '0);
    chk("rst_nerr", 136'(num_errors), '0);
    chk("rst_fail", 136'(fail), '0);
    chk("rst_valid", 136'(lambda_valid), '0);
    chk("rst_state", 136'(bm_state), 136'(BM_IDLE));
    rst_in = 1'b1;

    foreach (vecs[v]) begin
      start_run(vecs[v].pat, vecs[v].e);
      run_wait(lat, pulses, held);
      exp_l = 136'(vecs[v].l0) | (136'(vecs[v].l1) << 8) | (136'(vecs[v].l2) << 16);
      chk({vecs[v].name, "_latency"}, 136'(lat), 136'(65));
      chk({vecs[v].name, "_pulses"}, 136'(pulses), 136'(1));
      chk({vecs[v].name, "_hold"}, 136'(held), 136'(1));
      chk({vecs[v].name, "_lambda"}, pack_lam(), exp_l);
      chk({vecs[v].name, "_nerr"}, 136'(num_errors), 136'(vecs[v].ne));
      chk({vecs[v].name, "_fail"}, 136'(fail), 136'(vecs[v].fl));
    end

    // lone new_cvcdu / lone data_valid_in are ignored
    @(posedge clk_in); #1;
    new_cvcdu = 1'b1;
    @(posedge clk_in); #1;
    new_cvcdu = 1'b0;
    data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    chk("lone_state", 136'(bm_state), 136'(BM_IDLE));
    snap = pack_lam();
    run_wait(lat, pulses, held);
    chk("lone_pulses", 136'(pulses), '0);
    chk("lone_hold", pack_lam(), snap);

    // restart 10 cycles into a run: only the second set's result appears
    start_run(1, 8'h01);
    repeat (10) @(posedge clk_in);
    start_run(2, 8'h00);
    run_wait(lat, pulses, held);
    chk("restart_latency", 136'(lat), 136'(65));
    chk("restart_pulses", 136'(pulses), 136'(1));
    chk("restart_lambda", pack_lam(), 136'h0201);
    chk("restart_nerr", 136'(num_errors), 136'(1));

    // reset mid-run
    start_run(3, 8'h00);
    repeat (20) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("midrst_lambda", pack_lam(), '0);
    chk("midrst_nerr", 136'(num_errors), '0);
    chk("midrst_state", 136'(bm_state), 136'(BM_IDLE));
    rst_in = 1'b1;
    snap = pack_lam();
    run_wait(lat, pulses, held);
    chk("midrst_pulses", 136'(pulses), '0);

    // field-sample syndromes: structural properties, then 20 us stability
    start_run(4, 8'h00);
    run_wait(lat, pulses, held);
    chk("field_latency", 136'(lat), 136'(65));
    chk("field_pulses", 136'(pulses), 136'(1));
    chk("field_l0", 136'(lambda[0]), 136'(1));
    deg = 0;
    for (int i = 0; i <= T; i++) if (lambda[i] != 8'h00) deg = i;
    chk("field_deg", 136'(fail || (deg == int'(num_errors) && num_errors <= 5'd16)), 136'(1));
    cap = pack_lam();
    cap_ne = num_errors;
    cap_fl = fail;
    unstable = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk_in); #1;
      if (pack_lam() !== cap || num_errors !== cap_ne || fail !== cap_fl || lambda_valid)
        unstable++;
    end
    chk("field_stable", 136'(unstable), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_error_polynomial.md
Name: rs_error_polynomial

Overview:
Berlekamp-Massey error-locator solver for the CCSDS RS(255,223) decoder in the LRPT chain (t = 16, 32 syndromes). It sits between the syndrome calculator and the Chien search / Forney stage. It latches 32 GF(2^8) syndromes and iteratively computes the normalized error-locator polynomial lambda(x), with lambda[0] = 1 and degree <= 16. It reports the locator degree and an uncorrectable flag.

Parameters:
GF_POLY, 9'h187, field primitive polynomial x^8+x^7+x^2+x+1; alpha = 8'h02.
NSYM, 32, number of syndromes (2t).
T, 16, correction capability; lambda has T+1 coefficients.

Ports:
clk_in  input  1  system clock; all logic on the rising edge.
rst_in  input  1  synchronous, active-low reset.
new_cvcdu  input  1  marks the syndrome set of a new codeword.
syndrome  input  [7:0] x NSYM (unpacked [31:0])  S0..S31, element i = S_i; conventional basis.
data_valid_in  input  1  syndrome array is valid this cycle.
lambda  output  [7:0] x (T+1) (unpacked [16:0])  locator coefficients; lambda[i] multiplies x^i.
lambda_valid  output  1  one-cycle pulse when lambda, num_errors and fail are final.
num_errors  output  5  final LFSR length L (0..16).
fail  output  1  set when L would exceed T; codeword is uncorrectable.

Behaviour:
- Reset (rst_in low at a clock edge): FSM goes to IDLE. lambda, num_errors, fail, lambda_valid and all internal registers clear to 0.
- Start condition: new_cvcdu && data_valid_in, sampled at an edge. On start, the block copies the syndromes into an internal register and initializes the iteration:
  - lambda_int = 1, B = 1 (x^0 coefficient).
  - L = 0, r = 0, prev discrepancy b = 1.
- A start while busy aborts the current run and restarts with the new syndromes.
- new_cvcdu or data_valid_in asserted alone is ignored.
- FSM states: IDLE -> DISC -> UPDATE -> (DISC while r < 32, else DONE) -> IDLE.
- DISC (1 cycle): delta = XOR over i = 0..min(r,16) of lambda_int[i] * S[r-i], using 17 parallel GF multipliers; result is registered.
- UPDATE (1 cycle), standard normalized BM:
  - If delta == 0: B = x*B.
  - Else compute T(x) = lambda_int - (delta * b^-1) * x * B.
    - If 2L <= r: B = lambda_int * delta^-1 (equivalently B = lambda_int with b = delta), L = r+1-L, then lambda_int = T.
    - Otherwise: lambda_int = T and B = x*B.
  - Then r = r+1.
  - If the new L > 16, fail is set sticky for this codeword, and L saturates for the output.
  - Coefficients shifted beyond x^16 are discarded.
- DONE (1 cycle): the block drives lambda = lambda_int and num_errors = L, pulses lambda_valid high for exactly this cycle, then returns to IDLE.
- Outputs hold their values until the next start or reset. lambda, num_errors and fail do not change mid-run; they update only in DONE.
- Latency: 32 x 2 = 64 iteration cycles; lambda_valid is high in the cycle after the 65th rising edge following the start edge.
- GF arithmetic:
  - Addition is XOR.
  - Multiplication is a combinational shift-and-add reduced by GF_POLY.
  - Inverse is a^254 or a 256-entry ROM; the inverse of 0 is never used because b != 0 by construction.
- An all-zero syndrome set yields lambda = {1,0,...,0}, num_errors = 0, fail = 0.

Decomposition:
- Package rs_pkg holds:
  - constants GF_POLY, NSYM, T;
  - typedef gf_t (logic [7:0]);
  - pure functions gf_mul and gf_inv, shared with the Chien and Forney stages.
- One natural sub-module, rs_bm_discrepancy: a 17-term GF dot product of lambda_int against a windowed syndrome slice.
- The FSM and register update stay in rs_error_polynomial.

Test Plan:
- All 32 syndromes = 0, start pulse -> lambda_valid after 65 edges; lambda = {1,0,...}, num_errors = 0, fail = 0.
- All S_i = 1 (single error at X = 1, e = 1) -> lambda[0] = 1, lambda[1] = 1, rest 0; num_errors = 1.
- S_i = 2^i in the field (X = alpha) -> lambda = 1 + 2x; num_errors = 1.
- S_i = 1 XOR 2^i (errors at 1 and alpha) -> lambda[0] = 1, lambda[1] = 3, lambda[2] = 2, rest 0; num_errors = 2; fail = 0.
- Field-sample set:
  - S = {23,75,152,55,84,92,239,58,75,162,90,28,236,127,202,8,64,67,119,31,77,17,190,182,96,99,18,38,31,119,216,138}, start for one cycle.
  - Required: lambda_valid exactly once, lambda[0] = 1, deg(lambda) = num_errors <= 16 unless fail = 1.
  - Outputs stable for 20 us afterwards.
- Restart and reset:
  - A second start 10 cycles into a run -> result matches the second syndrome set, and only one lambda_valid pulse occurs.
  - rst_in low mid-run -> all outputs 0 and no lambda_valid pulse.
